// File: rtl/board_input_debounce_if.sv
// Board-input debounce bundle: raw pins in, debounced levels and edge pulses out.
// The master drives the pins; the slave is the debounce block.
interface board_input_debounce_if #(
  parameter int unsigned NumIn = 8
);
  logic [NumIn-1:0] async_i;
  logic [NumIn-1:0] level_o;
  logic [NumIn-1:0] rise_o;
  logic [NumIn-1:0] fall_o;
  logic             stable_o;

  modport master (
    output async_i,
    input  level_o,
    input  rise_o,
    input  fall_o,
    input  stable_o
  );

  modport slave (
    input  async_i,
    output level_o,
    output rise_o,
    output fall_o,
    output stable_o
  );
endinterface

// File: rtl/board_input_debounce.sv
// Synchronizes and debounces asynchronous board inputs (DIP switches, buttons, card-detect),
// producing clean levels plus single-cycle rise/fall pulses per channel.
module board_input_debounce #(
  parameter int unsigned      NumIn          = 8,
  parameter int unsigned      SyncStages     = 2,
  parameter int unsigned      DebounceCycles = 50000,
  parameter logic [NumIn-1:0] ResetVal       = '0
) (
  input logic                    soc_clk,
  input logic                    rst_n,
  board_input_debounce_if.slave  bus
);

  localparam int unsigned      CntW   = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0][NumIn-1:0] sync_q;
  logic [NumIn-1:0]                 sync_s;
  logic [NumIn-1:0]                 level_q, level_d;
  logic [NumIn-1:0]                 rise_q, rise_d;
  logic [NumIn-1:0]                 fall_q, fall_d;
  logic [NumIn-1:0][CntW-1:0]       cnt_q, cnt_d;

  // Stage 0 captures the pin; stage SyncStages-1 is the value the debouncer sees.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SyncStages{ResetVal}};
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], bus.async_i};
    end
  end

  assign sync_s = sync_q[SyncStages-1];

  // Any cycle that agrees with the current level discards the pending count.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < NumIn; i++) begin
      if (sync_s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        level_d[i] = sync_s[i];
        cnt_d[i]   = '0;
        rise_d[i]  = sync_s[i];
        fall_d[i]  = ~sync_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= ResetVal;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.level_o  = level_q;
  assign bus.rise_o   = rise_q;
  assign bus.fall_o   = fall_q;
  assign bus.stable_o = (sync_s == level_q);

endmodule

// File: tb/tb_board_input_debounce.sv
// Bench for board_input_debounce: directed scenarios plus random pin activity, all checked
// every cycle against a sliding-window reference model.
module tb_board_input_debounce;

  localparam int unsigned NI = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;
  localparam logic [NI-1:0] RV = 4'b0000;

  logic soc_clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  board_input_debounce_if #(.NumIn(NI)) bus ();

  board_input_debounce #(
    .NumIn         (NI),
    .SyncStages    (SS),
    .DebounceCycles(DC),
    .ResetVal      (RV)
  ) dut (
    .soc_clk(soc_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial begin
    soc_clk = 1'b0;
    forever #5 soc_clk = ~soc_clk;
  end

  task automatic check(input string name, input logic [NI-1:0] act, input logic [NI-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: pins sampled per edge; the debouncer at each edge sees the pin value
  // sampled SS edges earlier. A channel flips when the last DC seen values all disagree.
  logic [NI-1:0] pin_hist[$];
  logic [NI-1:0] seen_hist[$];
  logic [NI-1:0] m_s, m_lvl, m_rise, m_fall;

  always @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_hist.delete();
      seen_hist.delete();
      m_s    = RV;
      m_lvl  = RV;
      m_rise = '0;
      m_fall = '0;
    end else begin
      seen_hist.push_back(m_s);
      pin_hist.push_back(bus.async_i);
      m_s    = (pin_hist.size() >= SS) ? pin_hist[pin_hist.size() - SS] : RV;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < NI; i++) begin
        logic accept;
        logic [NI-1:0] v;
        accept = (seen_hist.size() >= DC);
        for (int j = 0; j < DC && accept; j++) begin
          v = seen_hist[seen_hist.size() - 1 - j];
          if (v[i] == m_lvl[i]) accept = 1'b0;
        end
        if (accept) begin
          m_lvl[i] = ~m_lvl[i];
          if (m_lvl[i]) m_rise[i] = 1'b1;
          else          m_fall[i] = 1'b1;
        end
      end
      if (pin_hist.size() > 16) void'(pin_hist.pop_front());
      if (seen_hist.size() > 16) void'(seen_hist.pop_front());
    end
  end

  always @(negedge soc_clk) begin
    check("model_level", bus.level_o, m_lvl);
    check("model_rise", bus.rise_o, m_rise);
    check("model_fall", bus.fall_o, m_fall);
    check("model_stable", NI'(bus.stable_o), NI'(m_s == m_lvl));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge soc_clk);
  endtask

  task automatic drive(input logic [NI-1:0] v);
    #1 bus.async_i = v;
  endtask

  initial begin
    logic [NI-1:0] v;
    int            pulses;
    int            r2;
    int            hold;
    n_chk       = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bus.async_i = 4'b1111;

    // Reset state, then release with all pins high.
    tick(3);
    check("rst_level", bus.level_o, 4'b0000);
    check("rst_rise", bus.rise_o, 4'b0000);
    check("rst_fall", bus.fall_o, 4'b0000);
    #1 rst_n = 1'b1;
    tick(5);
    check("rel_level_e5", bus.level_o, 4'b0000);
    tick(1);
    check("rel_level_e6", bus.level_o, 4'b1111);
    check("rel_rise_e6", bus.rise_o, 4'b1111);
    tick(1);
    check("rel_rise_e7", bus.rise_o, 4'b0000);

    drive(4'b0000);
    tick(10);
    check("settle0", bus.level_o, 4'b0000);

    // Clean rise on channel 0.
    drive(4'b0001);
    tick(1);
    check("rise_stable_e0", NI'(bus.stable_o), 4'b0001);
    tick(1);
    check("rise_stable_e1", NI'(bus.stable_o), 4'b0000);
    tick(3);
    check("rise_level_e4", bus.level_o, 4'b0000);
    tick(1);
    check("rise_level_e5", bus.level_o, 4'b0001);
    check("rise_pulse_e5", bus.rise_o, 4'b0001);
    check("rise_stable_e5", NI'(bus.stable_o), 4'b0001);
    tick(1);
    check("rise_pulse_e6", bus.rise_o, 4'b0000);

    // Glitch of three cycles on channel 1 must be rejected.
    drive(4'b0011);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) drive(4'b0001);
      tick(1);
      pulses += $countones(bus.rise_o | bus.fall_o);
    end
    check("glitch_pulses", NI'(pulses), 4'd0);
    check("glitch_level", bus.level_o, 4'b0001);
    drive(4'b0011);
    tick(6);
    check("hold_rise1", bus.rise_o, 4'b0010);
    tick(2);

    // Bounce on channel 2, ending high.
    v  = 4'b0011;
    r2 = 0;
    for (int k = 0; k < 20; k++) begin
      v[2] = ~v[2];
      drive(v);
      tick(1);
      r2 += int'(bus.rise_o[2]);
    end
    v[2] = 1'b1;
    drive(v);
    tick(5);
    r2 += int'(bus.rise_o[2]);
    check("bounce_early", bus.level_o, 4'b0011);
    tick(1);
    r2 += int'(bus.rise_o[2]);
    check("bounce_rise_e5", bus.rise_o, 4'b0100);
    tick(3);
    r2 += int'(bus.rise_o[2]);
    check("bounce_count", NI'(r2), 4'd1);

    // Simultaneous change: channel 0 falls, channel 3 rises.
    drive(4'b1110);
    tick(5);
    check("simul_level_e4", bus.level_o, 4'b0111);
    tick(1);
    check("simul_level_e5", bus.level_o, 4'b1110);
    check("simul_rise", bus.rise_o, 4'b1000);
    check("simul_fall", bus.fall_o, 4'b0001);
    tick(2);

    // Reset during a pending count on channel 0.
    drive(4'b0000);
    tick(10);
    drive(4'b0001);
    tick(5);
    #1 rst_n = 1'b0;
    tick(2);
    check("midrst_level", bus.level_o, 4'b0000);
    check("midrst_rise", bus.rise_o, 4'b0000);
    #1 rst_n = 1'b1;
    tick(5);
    check("midrst_rel_e5", bus.level_o, 4'b0000);
    tick(1);
    check("midrst_rel_rise", bus.rise_o, 4'b0001);
    check("midrst_rel_level", bus.level_o, 4'b0001);

    // Random pin activity with varying toggle density and occasional resets.
    hold = 8;
    for (int k = 0; k < 3000; k++) begin
      tick(1);
      #1;
      if (k % 200 == 0) hold = (k / 200 % 3 == 0) ? 2 : ((k / 200 % 3 == 1) ? 8 : 24);
      v = bus.async_i;
      for (int i = 0; i < NI; i++) begin
        if ($urandom_range(hold - 1) == 0) v[i] = ~v[i];
      end
      bus.async_i = v;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(999) == 0) rst_n = 1'b0;
    end
    rst_n = 1'b1;
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
